// File: rtl/dse_pkg.sv
// Shared types and constants for the digit spike encoder: FSM state encoding,
// index/counter widths and the drop-counter saturation value.
package dse_pkg;

  localparam int DEF_PIXELS = 25;
  localparam int DEF_LABELS = 10;

  // Width of a 1-based index able to hold 0..n
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int ADDR_W = idx_w(DEF_PIXELS);
  localparam int LIDX_W = idx_w(DEF_LABELS);
  localparam int CNT_W  = 8;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_GAP   = 3'd2,
    ST_LAG   = 3'd3,
    ST_LABEL = 3'd4,
    ST_DONE  = 3'd5
  } dse_state_t;

endpackage

// File: rtl/dse_if.sv
// Pattern-in / spike-out bundle of the digit spike encoder. Inputs are single-cycle
// pulses with no backpressure; every output strobe is a one-cycle event, at most one per cycle.
interface dse_if import dse_pkg::*; #(
  parameter int P_PIXELS = DEF_PIXELS,
  parameter int P_LABELS = DEF_LABELS
) ();

  localparam int AW = idx_w(P_PIXELS);
  localparam int LW = idx_w(P_LABELS);

  logic [P_PIXELS:1]  i_test_vector;
  logic [P_LABELS:1]  i_label;
  logic               o_busy;
  logic               o_spike_valid;
  logic [AW-1:0]      o_spike_addr;
  logic               o_label_valid;
  logic [LW-1:0]      o_label_idx;
  logic               o_label_err;
  logic               o_pattern_done;
  logic [DROP_W-1:0]  o_drop_count;
  dse_state_t         o_state;

  modport master (
    output i_test_vector, i_label,
    input  o_busy, o_spike_valid, o_spike_addr, o_label_valid, o_label_idx,
           o_label_err, o_pattern_done, o_drop_count, o_state
  );

  modport slave (
    input  i_test_vector, i_label,
    output o_busy, o_spike_valid, o_spike_addr, o_label_valid, o_label_idx,
           o_label_err, o_pattern_done, o_drop_count, o_state
  );

endinterface

// File: rtl/dse_lowest_set.sv
// Priority encoder: 1-based index of the lowest set bit of a [W:1] vector,
// 0 when the vector is empty, plus an any-set flag.
module dse_lowest_set #(
  parameter int W = 8
) (
  input  logic [W:1]               vec,
  output logic [$clog2(W+1)-1:0]   idx,
  output logic                     any
);

  localparam int IW = $clog2(W + 1);

  // Scan downward so the last hit written is the lowest index
  always_comb begin
    idx = '0;
    for (int i = W; i >= 1; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/digit_spike_encoder.sv
// Captures a digit pattern + one-hot label pulse and replays it as address-event
// pixel spikes followed by a label spike. DSE_DROP_COUNT_EN enables the drop counter.
module digit_spike_encoder import dse_pkg::*; #(
  parameter int P_PIXELS    = DEF_PIXELS,
  parameter int P_LABELS    = DEF_LABELS,
  parameter int P_SPIKE_GAP = 4,
  parameter int P_LABEL_LAG = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  dse_if.slave   bus
);

  localparam int AW = idx_w(P_PIXELS);
  localparam int LW = idx_w(P_LABELS);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(P_SPIKE_GAP);
  localparam logic [CNT_W-1:0] LAG_LOAD = CNT_W'(P_LABEL_LAG);

  dse_state_t         state, state_nx;
  logic [P_PIXELS:1]  pix_sh, pix_rem;
  logic [P_LABELS:1]  lbl_sh;
  logic [CNT_W-1:0]   cnt;
  logic [AW-1:0]      pix_idx;
  logic [LW-1:0]      lbl_idx;
  logic               pix_any, lbl_any, lbl_multi;
  logic               pattern, accept;

  logic               busy_d, spike_valid_d, label_valid_d, label_err_d, done_d;
  logic [AW-1:0]      spike_addr_d;
  logic [LW-1:0]      label_idx_d;
  logic               busy_q, spike_valid_q, label_valid_q, label_err_q, done_q;
  logic [AW-1:0]      spike_addr_q;
  logic [LW-1:0]      label_idx_q;

  dse_lowest_set #(.W(P_PIXELS)) u_pix_enc (.vec(pix_sh), .idx(pix_idx), .any(pix_any));
  dse_lowest_set #(.W(P_LABELS)) u_lbl_enc (.vec(lbl_sh), .idx(lbl_idx), .any(lbl_any));

  assign pattern   = (|bus.i_test_vector) | (|bus.i_label);
  // The o_pattern_done cycle already sits in IDLE but must still refuse input
  assign accept    = pattern && (state == ST_IDLE) && !done_q;
  assign pix_rem   = pix_sh & (pix_sh - P_PIXELS'(1));
  assign lbl_multi = |(lbl_sh & (lbl_sh - P_LABELS'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // A zero gap/lag load skips the corresponding wait state entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (|bus.i_test_vector)   state_nx = ST_SCAN;
          else if (LAG_LOAD == '0)  state_nx = ST_LABEL;
          else                      state_nx = ST_LAG;
        end
      end
      ST_SCAN: begin
        if (|pix_rem)               state_nx = (GAP_LOAD == '0) ? ST_SCAN : ST_GAP;
        else                        state_nx = (LAG_LOAD == '0) ? ST_LABEL : ST_LAG;
      end
      ST_GAP:   if (cnt <= CNT_W'(1)) state_nx = ST_SCAN;
      ST_LAG:   if (cnt <= CNT_W'(1)) state_nx = ST_LABEL;
      ST_LABEL: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d        = (state != ST_IDLE);
    spike_valid_d = 1'b0;
    spike_addr_d  = '0;
    label_valid_d = 1'b0;
    label_idx_d   = '0;
    label_err_d   = 1'b0;
    done_d        = 1'b0;
    unique case (state)
      ST_SCAN: begin
        spike_valid_d = pix_any;
        spike_addr_d  = pix_idx;
      end
      ST_LABEL: begin
        label_valid_d = lbl_any;
        label_idx_d   = lbl_idx;
        label_err_d   = lbl_any && lbl_multi;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      label_valid_q <= 1'b0;
      label_idx_q   <= '0;
      label_err_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      label_valid_q <= label_valid_d;
      label_idx_q   <= label_idx_d;
      label_err_q   <= label_err_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_sh <= '0;
      lbl_sh <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            pix_sh <= bus.i_test_vector;
            lbl_sh <= bus.i_label;
            cnt    <= LAG_LOAD;
          end
        end
        ST_SCAN: begin
          pix_sh <= pix_rem;
          cnt    <= (|pix_rem) ? GAP_LOAD : LAG_LOAD;
        end
        ST_GAP, ST_LAG: cnt <= cnt - CNT_W'(1);
        ST_DONE: lbl_sh <= '0;
        default: ;
      endcase
    end
  end

`ifdef DSE_DROP_COUNT_EN
  logic              drop;
  logic [DROP_W-1:0] drop_cnt;

  assign drop = pattern && !accept;

  always_ff @(posedge i_clk) begin
    if (i_rst)                              drop_cnt <= '0;
    else if (drop && (drop_cnt != DROP_SAT)) drop_cnt <= drop_cnt + DROP_W'(1);
  end

  assign bus.o_drop_count = drop_cnt;
`else
  assign bus.o_drop_count = '0;
`endif

  assign bus.o_busy         = busy_q;
  assign bus.o_spike_valid  = spike_valid_q;
  assign bus.o_spike_addr   = spike_addr_q;
  assign bus.o_label_valid  = label_valid_q;
  assign bus.o_label_idx    = label_idx_q;
  assign bus.o_label_err    = label_err_q;
  assign bus.o_pattern_done = done_q;
  assign bus.o_state        = state;

endmodule

// File: tb/tb_digit_spike_encoder.sv
// Directed bench for digit_spike_encoder: G=4/L=2 instance plus a G=0 instance,
// event logs timestamped relative to the capture edge, compared to hand-built queues.
module tb_digit_spike_encoder;
  import dse_pkg::*;

  localparam int W = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dse_if #(.P_PIXELS(25), .P_LABELS(10)) bus0 ();
  dse_if #(.P_PIXELS(25), .P_LABELS(10)) bus1 ();

  digit_spike_encoder #(.P_PIXELS(25), .P_LABELS(10), .P_SPIKE_GAP(4), .P_LABEL_LAG(2))
    dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  digit_spike_encoder #(.P_PIXELS(25), .P_LABELS(10), .P_SPIKE_GAP(0), .P_LABEL_LAG(2))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_cap  = 0;
  logic sel  = 1'b0;
  int busy_n, busy_first, busy_last;
  logic [W-1:0] exp_spk_q[$], obs_spk_q[$];
  logic [W-1:0] exp_lbl_q[$], obs_lbl_q[$];
  logic [W-1:0] exp_done_q[$], obs_done_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and log events relative to t_cap
  task automatic step();
    logic sv, lv, le, dn, by;
    logic [4:0] sa;
    logic [3:0] li;
    @(posedge clk);
    #1;
    cyc++;
    sv = sel ? bus1.o_spike_valid  : bus0.o_spike_valid;
    sa = sel ? bus1.o_spike_addr   : bus0.o_spike_addr;
    lv = sel ? bus1.o_label_valid  : bus0.o_label_valid;
    li = sel ? bus1.o_label_idx    : bus0.o_label_idx;
    le = sel ? bus1.o_label_err    : bus0.o_label_err;
    dn = sel ? bus1.o_pattern_done : bus0.o_pattern_done;
    by = sel ? bus1.o_busy         : bus0.o_busy;
    if (sv) obs_spk_q.push_back({32'(cyc - t_cap), 3'b000, sa});
    else    chk("spike_addr_idle", W'(sa), '0);
    if (lv) obs_lbl_q.push_back({32'(cyc - t_cap), 3'b000, le, li});
    else    chk("label_idle", W'({le, li}), '0);
    if (dn) obs_done_q.push_back({32'(cyc - t_cap), 8'h00});
    if (by) begin
      if (busy_n == 0) busy_first = cyc - t_cap;
      busy_last = cyc - t_cap;
      busy_n++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_logs();
    exp_spk_q.delete();  obs_spk_q.delete();
    exp_lbl_q.delete();  obs_lbl_q.delete();
    exp_done_q.delete(); obs_done_q.delete();
    busy_n = 0; busy_first = 0; busy_last = 0;
  endtask

  // Drive a one-cycle pattern pulse; is_new starts a fresh timestamp base
  task automatic pulse(input logic [25:1] vec, input logic [10:1] lbl, input bit is_new);
    if (is_new) clear_logs();
    if (sel) begin bus1.i_test_vector = vec; bus1.i_label = lbl; end
    else     begin bus0.i_test_vector = vec; bus0.i_label = lbl; end
    step();
    if (is_new) t_cap = cyc;
    bus0.i_test_vector = '0; bus0.i_label = '0;
    bus1.i_test_vector = '0; bus1.i_label = '0;
  endtask

  task automatic exp_spk(input int off, input int addr);
    exp_spk_q.push_back({32'(off), 8'(addr)});
  endtask

  task automatic exp_lbl(input int off, input bit err, input int idx);
    exp_lbl_q.push_back({32'(off), 3'b000, err, 4'(idx)});
  endtask

  task automatic exp_done(input int off);
    exp_done_q.push_back({32'(off), 8'h00});
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nspk"}, W'(obs_spk_q.size()), W'(exp_spk_q.size()));
    foreach (exp_spk_q[i])
      if (i < obs_spk_q.size()) chk($sformatf("%s_spk%0d", tag, i), obs_spk_q[i], exp_spk_q[i]);
    chk({tag, "_nlbl"}, W'(obs_lbl_q.size()), W'(exp_lbl_q.size()));
    foreach (exp_lbl_q[i])
      if (i < obs_lbl_q.size()) chk($sformatf("%s_lbl%0d", tag, i), obs_lbl_q[i], exp_lbl_q[i]);
    chk({tag, "_ndone"}, W'(obs_done_q.size()), W'(exp_done_q.size()));
    foreach (exp_done_q[i])
      if (i < obs_done_q.size()) chk($sformatf("%s_done%0d", tag, i), obs_done_q[i], exp_done_q[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  W'(bus0.o_busy), '0);
    chk({tag, "_spkv"},  W'(bus0.o_spike_valid), '0);
    chk({tag, "_spka"},  W'(bus0.o_spike_addr), '0);
    chk({tag, "_lblv"},  W'(bus0.o_label_valid), '0);
    chk({tag, "_lbli"},  W'(bus0.o_label_idx), '0);
    chk({tag, "_lble"},  W'(bus0.o_label_err), '0);
    chk({tag, "_done"},  W'(bus0.o_pattern_done), '0);
    chk({tag, "_drop"},  W'(bus0.o_drop_count), '0);
    chk({tag, "_state"}, W'(bus0.o_state), W'(ST_IDLE));
  endtask

  initial begin
    int exp_drops;
    rst = 1'b1;
    bus0.i_test_vector = '0; bus0.i_label = '0;
    bus1.i_test_vector = '0; bus1.i_label = '0;
    run(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    run(2);

    // Pixels {1,3}, label 7
    sel = 1'b0;
    pulse(25'h0000005, 10'h040, 1'b1);
    run(14);
    exp_spk(1, 1); exp_spk(6, 3); exp_lbl(9, 1'b0, 7); exp_done(10);
    compare("t1");
    chk("t1_busy_n",     W'(busy_n), W'(10));
    chk("t1_busy_first", W'(busy_first), W'(1));
    chk("t1_busy_last",  W'(busy_last), W'(10));

    // All 25 pixels, zero gap
    sel = 1'b1;
    pulse(25'h1FFFFFF, 10'h001, 1'b1);
    run(35);
    for (int k = 1; k <= 25; k++) exp_spk(k, k);
    exp_lbl(28, 1'b0, 1); exp_done(29);
    compare("t2");
    chk("t2_busy_n", W'(busy_n), W'(29));
    sel = 1'b0;

    // Empty vector, label 2
    pulse(25'h0000000, 10'h002, 1'b1);
    run(8);
    exp_lbl(3, 1'b0, 2); exp_done(4);
    compare("t3");
    chk("t3_busy_n", W'(busy_n), W'(4));

    // Pixel 5, label bits {4,9}: lowest index with error flag
    pulse(25'h0000010, 10'h108, 1'b1);
    run(10);
    exp_spk(1, 5); exp_lbl(4, 1'b1, 4); exp_done(5);
    compare("t4");

    // Drops: three while busy, one on the done cycle
    pulse(25'h0000005, 10'h040, 1'b1);
    wait_until(t_cap + 1);  pulse(25'h1FFFFFF, 10'h3FF, 1'b0);
    wait_until(t_cap + 4);  pulse(25'h0000002, 10'h000, 1'b0);
    wait_until(t_cap + 7);  pulse(25'h0000000, 10'h001, 1'b0);
    wait_until(t_cap + 10); pulse(25'h0000008, 10'h001, 1'b0);
    run(6);
    exp_spk(1, 1); exp_spk(6, 3); exp_lbl(9, 1'b0, 7); exp_done(10);
    compare("t5");
`ifdef DSE_DROP_COUNT_EN
    exp_drops = 4;
`else
    exp_drops = 0;
`endif
    chk("t5_drops", W'(bus0.o_drop_count), W'(exp_drops));
    chk("t5_idle",  W'(bus0.o_state), W'(ST_IDLE));
    chk("t5_busy",  W'(bus0.o_busy), '0);

    // Reset in GAP after the 2nd spike, then a fresh pattern straight away
    pulse(25'h0000015, 10'h001, 1'b1);
    wait_until(t_cap + 7);
    rst = 1'b1;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    pulse(25'h0000005, 10'h040, 1'b1);
    run(14);
    exp_spk(1, 1); exp_spk(6, 3); exp_lbl(9, 1'b0, 7); exp_done(10);
    compare("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
